// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready load and optional start/stop framing.
// Every output is registered and is derived from the next-state values.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BAUD_DIV  = 1,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned FRAMED    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic [WIDTH-1:0] shreg_shifted;

  assign bit_end       = (baud_q == BAUD_LAST);
  assign shreg_shifted = (LSB_FIRST != 0) ? {1'b0, shreg_q[WIDTH-1:1]}
                                          : {shreg_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    baud_d   = baud_q;
    case (state_q)
      StIdle: begin
        if (load_valid) begin
          shreg_d  = load_data;
          bitcnt_d = '0;
          baud_d   = '0;
          state_d  = (FRAMED != 0) ? StStart : StData;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d = '0;
          if (bitcnt_q == CNT_LAST) begin
            bitcnt_d = '0;
            state_d  = (FRAMED != 0) ? StStop : StIdle;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
            shreg_d  = shreg_shifted;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from next-state so they land on the same edge as the state change.
  always_comb begin
    sout_d       = 1'b1;
    sout_valid_d = 1'b0;
    done_d       = (state_q != StIdle) && (state_d == StIdle);
    case (state_d)
      StStart: sout_d = 1'b0;
      StData: begin
        sout_d       = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[WIDTH-1];
        sout_valid_d = 1'b1;
      end
      default: sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      baud_q       <= '0;
      sout_q       <= 1'b1;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      baud_q       <= baud_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);
  assign load_ready = (state_q == StIdle);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: three serializer configurations sharing one clock and reset.
// u0: framed LSB-first div 1; u1: framed LSB-first div 4; u2: unframed MSB-first div 1.
module tb_piso_serializer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] lv    = '0;
  logic [7:0] ld [3];
  logic [2:0] lr, so, sv, bz, dn;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .BAUD_DIV(1), .LSB_FIRST(1), .FRAMED(1)) u0 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr[0]),
    .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]), .done(dn[0])
  );
  piso_serializer #(.WIDTH(8), .BAUD_DIV(4), .LSB_FIRST(1), .FRAMED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr[1]),
    .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]), .done(dn[1])
  );
  piso_serializer #(.WIDTH(8), .BAUD_DIV(1), .LSB_FIRST(0), .FRAMED(0)) u2 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_data(ld[2]), .load_ready(lr[2]),
    .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]), .done(dn[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int u, input string tag);
    chk({tag, " sout"}, 32'(so[u]), 32'd1);
    chk({tag, " sout_valid"}, 32'(sv[u]), 32'd0);
    chk({tag, " busy"}, 32'(bz[u]), 32'd0);
    chk({tag, " load_ready"}, 32'(lr[u]), 32'd1);
    chk({tag, " done"}, 32'(dn[u]), 32'd0);
  endtask

  // Called in the first cycle after the accept edge; returns in the done cycle.
  task automatic expect_frame(input int u, input logic [7:0] w, input int baud,
                              input bit framed, input bit lsb, input string tag);
    int   nb;
    int   k;
    int   b;
    logic e;
    logic ev;
    nb = framed ? 10 : 8;
    for (int i = 0; i < nb * baud; i++) begin
      k = i / baud;
      if (framed && k == 0) begin
        e = 1'b0; ev = 1'b0;
      end else if (framed && k == nb - 1) begin
        e = 1'b1; ev = 1'b0;
      end else begin
        b  = framed ? k - 1 : k;
        e  = lsb ? w[b] : w[7-b];
        ev = 1'b1;
      end
      chk($sformatf("%s sout c%0d", tag, i + 1), 32'(so[u]), 32'(e));
      chk($sformatf("%s sout_valid c%0d", tag, i + 1), 32'(sv[u]), 32'(ev));
      chk($sformatf("%s done c%0d", tag, i + 1), 32'(dn[u]), 32'd0);
      chk($sformatf("%s busy c%0d", tag, i + 1), 32'(bz[u]), 32'd1);
      chk($sformatf("%s load_ready c%0d", tag, i + 1), 32'(lr[u]), 32'd0);
      tick();
    end
    chk({tag, " done pulse"}, 32'(dn[u]), 32'd1);
    chk({tag, " done-cycle sout"}, 32'(so[u]), 32'd1);
    chk({tag, " done-cycle busy"}, 32'(bz[u]), 32'd0);
    chk({tag, " done-cycle load_ready"}, 32'(lr[u]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) ld[i] = '0;

    // Asynchronous reset mid-cycle, no clock edge before the check.
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) chk_idle(u, $sformatf("reset u%0d", u));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk_idle(0, "post-reset u0");

    // Framed LSB-first 0xA5 at one cycle per bit.
    lv[0] = 1'b1; ld[0] = 8'hA5;
    tick();
    lv[0] = 1'b0;
    expect_frame(0, 8'hA5, 1, 1'b1, 1'b1, "a5");
    tick();
    chk_idle(0, "a5 after");

    // Baud divider 4, 0x0F: 40-cycle frame, single done pulse.
    lv[1] = 1'b1; ld[1] = 8'h0F;
    tick();
    lv[1] = 1'b0;
    expect_frame(1, 8'h0F, 4, 1'b1, 1'b1, "div4");
    tick();
    chk_idle(1, "div4 after");

    // MSB-first unframed 0x81: 1,0,0,0,0,0,0,1 then done in cycle 9.
    lv[2] = 1'b1; ld[2] = 8'h81;
    tick();
    lv[2] = 1'b0;
    expect_frame(2, 8'h81, 1, 1'b0, 1'b0, "msb");
    tick();
    chk_idle(2, "msb after");

    // load_valid held with 0x3C through a 0xA5 frame; 0x3C is taken only in the done cycle.
    lv[0] = 1'b1; ld[0] = 8'hA5;
    tick();
    ld[0] = 8'h3C;
    expect_frame(0, 8'hA5, 1, 1'b1, 1'b1, "hold a5");
    tick();
    lv[0] = 1'b0;
    expect_frame(0, 8'h3C, 1, 1'b1, 1'b1, "hold 3c");
    tick();
    chk_idle(0, "hold after");

    // Reset during data bit 3 (cycle 5 of the frame).
    lv[0] = 1'b1; ld[0] = 8'hA5;
    tick();
    lv[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst bit3 before reset", 32'(so[0]), 32'd0);
    chk("midrst valid before reset", 32'(sv[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle(0, "midrst async");
    tick();
    chk_idle(0, "midrst held");
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("midrst no done c%0d", i), 32'(dn[0]), 32'd0);
      chk($sformatf("midrst no busy c%0d", i), 32'(bz[0]), 32'd0);
    end
    lv[0] = 1'b1; ld[0] = 8'h55;
    tick();
    lv[0] = 1'b0;
    expect_frame(0, 8'h55, 1, 1'b1, 1'b1, "post-rst 55");
    tick();
    chk_idle(0, "post-rst after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter that produces the single-bit `d` stream a downstream D flip-flop or shift-register capture stage samples on `clk`.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per bit period, optionally framed with a start bit (0) and a stop bit (1).
- Serves as the stimulus/transmit end for the team's capture-side blocks.

Parameters:
- WIDTH, 8, data word width in bits; legal range ≥ 2.
- BAUD_DIV, 1, clock cycles per serial bit; legal range ≥ 1.
- LSB_FIRST, 1, 1 = transmit bit 0 first; 0 = transmit bit WIDTH-1 first.
- FRAMED, 1, 1 = wrap data in a start bit (0) and a stop bit (1); 0 = data bits only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load_data is valid.
- load_data  input  WIDTH  word to transmit.
- load_ready  output  1  block can accept a word; high in IDLE only.
- sout  output  1  serial output; idle level 1.
- sout_valid  output  1  high while sout carries a data bit (DATA state only).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst_n low, asynchronous, any state) forces:
  - state = IDLE, sout = 1, sout_valid = 0, busy = 0, done = 0;
  - shift register, bit counter and baud counter = 0;
  - load_ready = 1.
- Reset release is synchronous to the next clk edge.
- Handshake:
  - A word is accepted on a rising edge where load_valid & load_ready.
  - load_data is copied into an internal shift register at that edge.
  - load_valid while not in IDLE is ignored; nothing is queued and the held word is not corrupted.
- States:
  - IDLE → START on accept, if FRAMED = 1.
  - IDLE → DATA on accept, if FRAMED = 0.
  - START → DATA after BAUD_DIV cycles; sout = 0 during START.
  - DATA → STOP after WIDTH bit periods, if FRAMED = 1.
  - DATA → IDLE after WIDTH bit periods, if FRAMED = 0.
  - STOP → IDLE after BAUD_DIV cycles; sout = 1 during STOP.
- Bit timing:
  - The baud counter counts 0..BAUD_DIV-1.
  - It wraps to 0 at each bit boundary and at each state change.
  - With BAUD_DIV = 1, the bit changes every cycle.
- DATA:
  - sout = current bit: shift-register LSB if LSB_FIRST, else MSB.
  - The register shifts at each bit boundary.
  - The bit counter counts 0..WIDTH-1; the final boundary exits DATA.
- All outputs are registered; sout changes only on clk edges.
- Latency: the first frame bit appears on sout in the cycle immediately after the accept edge.
- Frame length: (WIDTH + 2·FRAMED)·BAUD_DIV cycles.
- done:
  - High for exactly the first cycle back in IDLE.
  - load_ready is also high in that cycle, so back-to-back frames are separated by exactly one idle cycle at sout = 1.
- Out-of-range values: BAUD_DIV = 0 and WIDTH < 2 are illegal; behaviour is undefined and no check is required.

Test Plan:
- Reset values: assert rst_n = 0 mid-cycle, no clock edge → sout = 1, busy = 0, load_ready = 1, done = 0 immediately.
- Framed LSB-first word: WIDTH = 8, BAUD_DIV = 1, FRAMED = 1, LSB_FIRST = 1, load 0xA5.
  - sout over the 10 cycles after accept = 0,1,0,1,0,0,1,0,1,1.
  - sout_valid is high for cycles 2–9 only.
  - done = 1 in cycle 11, then 0.
- Baud divider: BAUD_DIV = 4, load 0x0F → each bit held exactly 4 cycles; frame lasts 40 cycles; done pulses once.
- MSB-first, unframed: FRAMED = 0, LSB_FIRST = 0, load 0x81 → sout = 1,0,0,0,0,0,0,1; no start or stop bit; done in cycle 9.
- Load ignored while busy: hold load_valid = 1 with 0x3C throughout a 0xA5 frame.
  - The 0xA5 frame is transmitted unmodified.
  - 0x3C is accepted only in the done cycle.
  - Its start bit begins after exactly one sout = 1 idle cycle.
- Reset mid-frame: drop rst_n during data bit 3 → sout = 1, busy = 0, done never pulses. After release, a new load of 0x55 transmits a complete, correct frame.
